// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_counter
// Brief   : Millisecond stopwatch with run/pause FSM, lap freeze and sticky
//           overflow; count feeds an external ms/s/min/hr converter.
// Revision: 1.0 - initial release
// ============================================================================
module stopwatch_counter #(
  parameter int BITS       = 29,
  parameter int CLK_PER_MS = 1000,
  parameter int MAX_MS     = 360000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_stop,
  input  logic            clear,
  input  logic            lap,
  output logic [BITS-1:0] count,
  output logic            running,
  output logic            lap_active,
  output logic            overflow
);

  localparam int              c_PW       = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(CLK_PER_MS - 1);
  localparam logic [BITS-1:0] c_MS_LAST  = BITS'(MAX_MS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [c_PW-1:0] pre_q,   pre_d;
  logic [BITS-1:0] ms_q,    ms_d;
  logic [BITS-1:0] lap_q,   lap_d;
  logic            lap_act_q, lap_act_d;
  logic            ovf_q,   ovf_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      ms_q      <= '0;
      lap_q     <= '0;
      lap_act_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      ms_q      <= ms_d;
      lap_q     <= lap_d;
      lap_act_q <= lap_act_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    ms_d      = ms_q;
    lap_d     = lap_q;
    lap_act_d = lap_act_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE:    if (start_stop) state_d = RUN;
      RUN:     if (start_stop) state_d = PAUSE;
      PAUSE:   if (start_stop) state_d = RUN;
      default: state_d = IDLE;
    endcase

    // Prescaler only advances in RUN, so a pause keeps the partial millisecond.
    if (state_q == RUN) begin
      if (pre_q == c_PRE_LAST) begin
        pre_d = '0;
        if (ms_q == c_MS_LAST) begin
          ms_d  = '0;
          ovf_d = 1'b1;
        end else begin
          ms_d = ms_q + BITS'(1);
        end
      end else begin
        pre_d = pre_q + c_PW'(1);
      end
    end

    if (lap) begin
      if (lap_act_q) begin
        lap_act_d = 1'b0;
      end else if (state_q == RUN) begin
        lap_d     = ms_q;
        lap_act_d = 1'b1;
      end
    end

    // Clear outranks start_stop and lap everywhere except RUN, where it is dropped.
    if (clear && (state_q != RUN)) begin
      state_d   = IDLE;
      pre_d     = '0;
      ms_d      = '0;
      lap_d     = '0;
      lap_act_d = 1'b0;
      ovf_d     = 1'b0;
    end
  end

  assign count      = lap_act_q ? lap_q : ms_q;
  assign running    = (state_q == RUN);
  assign lap_active = lap_act_q;
  assign overflow   = ovf_q;

endmodule
`default_nettype wire
